tilemap_access_arbiter: RTL
===========================

Name: tilemap_access_arbiter

Overview:
Owns the single address/data port of the tile-map BRAM (SB_RAM40_4K, 16-bit words, 4-bit tile codes packed 4 per word). It shares that port between two requesters: the VGA renderer's tile fetch, which has fixed top priority, and game logic, which gets a req/ack read or read-modify-write of one cell. It sits between the VGA pixel pipeline, the game/player logic and the BRAM instance.

Parameters:
MAP_W, 20, map width in cells
MAP_H, 15, map height in cells
WORDS_PER_ROW, 5, words per map row, equal to ceil(MAP_W/4)
BASE_ADDR, 0, BRAM word address of cell (0,0)
FILL_TILE, 4'h1, tile code written by the optional clear

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  asynchronous reset, active-high
i_Vid_Req  in  1  video fetch request, one cell per cycle
i_Vid_Cell_X  in  5  video cell column
i_Vid_Cell_Y  in  4  video cell row
o_Vid_Valid  out  1  o_Vid_Tile valid
o_Vid_Tile  out  4  fetched tile code
i_Game_Req  in  1  game access request, held until ack
i_Game_We  in  1  1 = write cell, 0 = read cell
i_Game_Cell_X  in  5  game cell column
i_Game_Cell_Y  in  4  game cell row
i_Game_Tile  in  4  tile code to write
o_Game_Ack  out  1  one-cycle completion pulse
o_Game_Tile  out  4  read result, valid with ack
o_Game_Busy  out  1  game FSM not IDLE
o_Ram_Addr  out  11  BRAM word address
o_Ram_Wdata  out  16  BRAM write data
o_Ram_We  out  1  BRAM write enable
i_Ram_Rdata  in  16  BRAM read data, 1-cycle read latency

Behaviour:
- Addressing:
  - word = BASE_ADDR + Y*WORDS_PER_ROW + X/4.
  - nibble = X%4; nibble 0 is bits[3:0] and nibble 3 is bits[15:12].
  - A cell is in range only if X<MAP_W and Y<MAP_H.
- Reset: all outputs go to 0 and the FSM goes to IDLE. A pending write is dropped, and o_Ram_We is 0 immediately on reset.
- Port ownership is decided per cycle:
  - When i_Vid_Req=1, o_Ram_Addr is the video word address and o_Ram_We=0. The game FSM holds its state.
  - When i_Vid_Req=0, the game FSM drives the port.
- Video path:
  - Fixed latency of 2: the request is at cycle N, and o_Vid_Valid/o_Vid_Tile are registered at N+2.
  - The nibble select and range flag are pipelined alongside the read.
  - An out-of-range cell gives o_Vid_Tile=0 with o_Vid_Valid=1.
- Game FSM states are IDLE, RD, WAIT, WR and DONE (plus CLEAR when the optional feature is compiled in).
  - IDLE: if i_Game_Req=1, latch X, Y, We and Tile. If the cell is in range go to RD, otherwise go to DONE.
  - RD: if the port is free, issue the read and go to WAIT; otherwise stay.
  - WAIT: latch i_Ram_Rdata.
    - For a read, o_Game_Tile <= the selected nibble, then go to DONE.
    - For a write, merge i_Game_Tile into the selected nibble, keep the other 12 bits unchanged, then go to WR.
  - WR: if the port is free, drive o_Ram_We=1 for one cycle with the merged word and go to DONE; otherwise stay.
  - DONE: o_Game_Ack=1 for one cycle, then IDLE.
- Out-of-range game access: no RAM access; ack is given with o_Game_Tile=0.
- Handshake:
  - The requester holds req and operands stable until ack, then deasserts req.
  - A req still high in the cycle after ack starts a new access.
  - o_Game_Busy = (state != IDLE).
- Latency: with no video contention, ack arrives 3 cycles after accept for a read and 4 cycles after accept for a write. Each video-owned cycle spent in RD or WR adds 1 cycle.
- Coherency: only the game FSM writes, so video reads that interleave between RD and WR are harmless. The video path returns the old word until the WR cycle.

Optional Feature:
- Macro: TILEMAP_CLEAR_EN.
- When defined:
  - After reset deasserts, the FSM enters CLEAR.
  - It writes {4{FILL_TILE}} to words BASE_ADDR .. BASE_ADDR+MAP_H*WORDS_PER_ROW-1, ascending, one word per free cycle.
  - Video keeps priority and stalls the clear.
  - o_Game_Busy=1 throughout and no game req is accepted; the FSM then goes to IDLE.
  - Reset during CLEAR restarts the clear from BASE_ADDR.
- When undefined: the FSM leaves reset in IDLE and BRAM keeps its INIT contents.

Test Plan:
1. Game read (5,2), word 11 = 16'h2010, no video requests:
   - RAM read at address 11.
   - o_Game_Ack pulses 3 cycles after accept with o_Game_Tile=4'h1.
2. Game write (6,0) tile 2, word 1 = 16'h1111:
   - Exactly one o_Ram_We cycle with address 1 and data 16'h1211.
   - Ack follows; a readback of (6,0) returns 2.
3. Video priority: i_Vid_Req held high for 10 cycles across a pending write:
   - o_Ram_We stays 0 and the video address is on the port during those cycles.
   - Video tiles arrive correct at latency 2.
   - The write completes after the video burst ends.
4. Out of range:
   - Game write (20,3) → ack, no o_Ram_We.
   - Video fetch (3,15) → o_Vid_Valid=1, o_Vid_Tile=0.
5. Reset asserted while in WR under video stall:
   - o_Ram_We=0, o_Game_Busy=0 and no ack.
   - The word is unchanged after reset.
6. TILEMAP_CLEAR_EN defined:
   - After reset, 75 writes of 16'h1111 to addresses 0..74.
   - o_Game_Busy=1 until the last write.
   - A subsequent read of (19,14) returns 4'h1.

Source files
------------

// File: rtl/tilemap_access_arbiter.sv
// tilemap_access_arbiter: owns the single tile-map BRAM port. The video tile
// fetch has fixed top priority each cycle; game logic gets a req/ack read or
// read-modify-write of one 4-bit cell (4 cells packed per 16-bit word).
// Optional feature macro: TILEMAP_CLEAR_EN (fill the map with FILL_TILE after reset).
module tilemap_access_arbiter #(
    parameter int unsigned MAP_W         = 20,
    parameter int unsigned MAP_H         = 15,
    parameter int unsigned WORDS_PER_ROW = 5,
    parameter int unsigned BASE_ADDR     = 0,
    parameter logic [3:0]  FILL_TILE     = 4'h1
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Vid_Req,
    input  logic [4:0]  i_Vid_Cell_X,
    input  logic [3:0]  i_Vid_Cell_Y,
    output logic        o_Vid_Valid,
    output logic [3:0]  o_Vid_Tile,
    input  logic        i_Game_Req,
    input  logic        i_Game_We,
    input  logic [4:0]  i_Game_Cell_X,
    input  logic [3:0]  i_Game_Cell_Y,
    input  logic [3:0]  i_Game_Tile,
    output logic        o_Game_Ack,
    output logic [3:0]  o_Game_Tile,
    output logic        o_Game_Busy,
    output logic [10:0] o_Ram_Addr,
    output logic [15:0] o_Ram_Wdata,
    output logic        o_Ram_We,
    input  logic [15:0] i_Ram_Rdata
);

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned TILE_W = 4;
    localparam int unsigned X_W    = 5;
    localparam int unsigned Y_W    = 4;
    localparam int unsigned NIB_W  = 2;

    localparam logic [WORD_W-1:0] FILL_WORD = {4{FILL_TILE}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WAIT  = 3'd2,
        WR    = 3'd3,
        DONE  = 3'd4
`ifdef TILEMAP_CLEAR_EN
        , CLEAR = 3'd5
`endif
    } state_t;

`ifdef TILEMAP_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
    localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(BASE_ADDR + MAP_H * WORDS_PER_ROW - 1);
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    // Word address of a cell: base + row * words-per-row + column / 4
    function automatic logic [ADDR_W-1:0] cell_word(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y);
        return ADDR_W'(BASE_ADDR) + ADDR_W'(y) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(x >> 2);
    endfunction

    function automatic logic cell_in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (32'(x) < MAP_W) && (32'(y) < MAP_H);
    endfunction

    // Nibble 0 is bits [3:0], nibble 3 is bits [15:12]
    function automatic logic [TILE_W-1:0] nib_get(input logic [WORD_W-1:0] w,
                                                  input logic [NIB_W-1:0]  n);
        return TILE_W'(w >> {n, 2'b00});
    endfunction

    function automatic logic [WORD_W-1:0] nib_put(input logic [WORD_W-1:0] w,
                                                  input logic [NIB_W-1:0]  n,
                                                  input logic [TILE_W-1:0] t);
        logic [WORD_W-1:0] mask;
        mask = WORD_W'(4'hF) << {n, 2'b00};
        return (w & ~mask) | ((WORD_W'(t) << {n, 2'b00}) & mask);
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   g_addr_q;
    logic [NIB_W-1:0]    g_nib_q;
    logic                g_we_q;
    logic [TILE_W-1:0]   g_tile_q;
    logic [WORD_W-1:0]   g_word_q;
    logic                v1_valid_q;
    logic [NIB_W-1:0]    v1_nib_q;
    logic                v1_inr_q;
    logic [ADDR_W-1:0]   ram_addr;
    logic [WORD_W-1:0]   ram_wdata;
    logic                ram_we;
    logic                game_inr;
`ifdef TILEMAP_CLEAR_EN
    logic [ADDR_W-1:0]   clr_addr_q;
`endif

    assign game_inr = cell_in_range(i_Game_Cell_X, i_Game_Cell_Y);

    // State register
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) state_q <= RESET_STATE;
        else         state_q <= state_d;
    end

    // Next state and per-cycle port ownership (video wins whenever it requests)
    always_comb begin
        state_d   = state_q;
        ram_addr  = g_addr_q;
        ram_wdata = (state_q == WR) ? g_word_q : FILL_WORD;
        ram_we    = 1'b0;
        if (i_Vid_Req) ram_addr = cell_word(i_Vid_Cell_X, i_Vid_Cell_Y);
        case (state_q)
            IDLE: if (i_Game_Req) state_d = game_inr ? RD : DONE;
            RD:   if (!i_Vid_Req) state_d = WAIT;
            WAIT: state_d = g_we_q ? WR : DONE;
            WR: begin
                if (!i_Vid_Req) begin
                    ram_we  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
`ifdef TILEMAP_CLEAR_EN
            CLEAR: begin
                if (!i_Vid_Req) begin
                    ram_addr = clr_addr_q;
                    ram_we   = 1'b1;
                    if (clr_addr_q == CLR_LAST) state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (i_Reset) begin
            ram_addr  = '0;
            ram_wdata = '0;
            ram_we    = 1'b0;
        end
    end

    assign o_Ram_Addr  = ram_addr;
    assign o_Ram_Wdata = ram_wdata;
    assign o_Ram_We    = ram_we;
    assign o_Game_Busy = !i_Reset && (state_q != IDLE);

    // Game operand capture, read-back nibble select and write merge
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            g_addr_q    <= '0;
            g_nib_q     <= '0;
            g_we_q      <= 1'b0;
            g_tile_q    <= '0;
            g_word_q    <= '0;
            o_Game_Tile <= '0;
            o_Game_Ack  <= 1'b0;
        end else begin
            o_Game_Ack <= (state_d == DONE);
            if (state_q == IDLE && i_Game_Req) begin
                g_addr_q <= cell_word(i_Game_Cell_X, i_Game_Cell_Y);
                g_nib_q  <= i_Game_Cell_X[1:0];
                g_we_q   <= i_Game_We;
                g_tile_q <= i_Game_Tile;
                if (!game_inr) o_Game_Tile <= '0;
            end
            if (state_q == WAIT) begin
                if (g_we_q) g_word_q    <= nib_put(i_Ram_Rdata, g_nib_q, g_tile_q);
                else        o_Game_Tile <= nib_get(i_Ram_Rdata, g_nib_q);
            end
        end
    end

    // Video pipeline: nibble select and range flag travel with the BRAM read
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            v1_valid_q  <= 1'b0;
            v1_nib_q    <= '0;
            v1_inr_q    <= 1'b0;
            o_Vid_Valid <= 1'b0;
            o_Vid_Tile  <= '0;
        end else begin
            v1_valid_q  <= i_Vid_Req;
            v1_nib_q    <= i_Vid_Cell_X[1:0];
            v1_inr_q    <= cell_in_range(i_Vid_Cell_X, i_Vid_Cell_Y);
            o_Vid_Valid <= v1_valid_q;
            o_Vid_Tile  <= (v1_valid_q && v1_inr_q) ? nib_get(i_Ram_Rdata, v1_nib_q) : '0;
        end
    end

`ifdef TILEMAP_CLEAR_EN
    // Clear address walks the map ascending, one word per free cycle
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)                             clr_addr_q <= CLR_FIRST;
        else if (state_q == CLEAR && !i_Vid_Req) clr_addr_q <= clr_addr_q + ADDR_W'(1);
    end
`endif

endmodule
